d_reg_bank: RTL and testbench
=============================

Name: d_reg_bank

Overview:
Parametrised multi-channel clocked data-hold register bank.
- Each channel captures its WIDTH-bit input when enabled.
- Two capture modes:
  - direct: capture on the next clock edge.
  - qualified: capture only after the input has been stable for STABLE_CYCLES consecutive enabled edges. This is the deglitch mode.
- Used as the general-purpose hold/sample stage for control and status inputs ahead of downstream logic.
- Per-channel update pulse and busy indication.

Parameters:
WIDTH, 8, data width per channel (>=1)
CHANNELS, 4, number of independent channels (>=1)
STABLE_CYCLES, 3, consecutive stable enabled samples required in qualified mode (>=1)

Ports:
clk  input  1  rising-edge clock
rstn  input  1  reset, synchronous, active-low
mode  input  1  0 = direct capture, 1 = qualified capture; sampled every edge, shared by all channels
en  input  CHANNELS  per-channel capture enable
d  input  CHANNELS*WIDTH  channel data, channel i at bits [i*WIDTH +: WIDTH]
q  output  CHANNELS*WIDTH  held data, same packing as d
updated  output  CHANNELS  one-cycle pulse, high for the cycle after q[i] was loaded
busy  output  CHANNELS  channel i is in QUALIFY state

Behaviour:
- Reset (rstn=0 at a rising edge): q=0, updated=0, busy=0; every channel goes to IDLE; counters and candidate registers cleared. Reset overrides all other inputs, including mid-qualification.
- All outputs are registered. Channels are fully independent; all channel state is evaluated per edge.
- Direct mode (mode=0), channel i:
  - en[i]=1 at edge k: q[i]<=d[i] and updated[i]=1 after edge k. Latency is 1 edge.
  - The load happens, and updated pulses, even if d[i]==q[i].
  - en[i]=0: q[i] holds, updated[i]=0.
  - If the channel was in QUALIFY, it returns to IDLE.
- Qualified mode (mode=1): per-channel FSM with states IDLE and QUALIFY, plus a candidate register cand and counter cnt of width $clog2(STABLE_CYCLES+1).
  - IDLE, en=1, d!=q:
    - If STABLE_CYCLES==1: load q<=d, pulse updated, stay IDLE.
    - Otherwise: cand<=d, cnt<=1, go to QUALIFY.
  - IDLE, en=1, d==q: stay IDLE, no pulse.
  - IDLE, en=0: stay IDLE.
  - QUALIFY, en=0: abort to IDLE; cnt<=0; q unchanged.
  - QUALIFY, en=1, d==cand:
    - If cnt+1==STABLE_CYCLES: q<=cand, updated pulse, go to IDLE, cnt<=0.
    - Otherwise: cnt<=cnt+1.
  - QUALIFY, en=1, d!=cand, d!=q: restart with cand<=d, cnt<=1.
  - QUALIFY, en=1, d==q: abort to IDLE with no update (the glitch returned to the held value).
  - Total latency: q changes on the STABLE_CYCLES-th consecutive enabled edge with identical d.
- Mode switch 1->0 while in QUALIFY: the direct-mode rule applies at that edge. With en=1, d is loaded immediately and the channel goes to IDLE.
- Mode switch 0->1: channel starts from IDLE.
- busy[i]=1 exactly while channel i is in QUALIFY.
- The counter never exceeds STABLE_CYCLES; there is no wrap-around.

Optional Feature:
Macro: DREG_STICKY_EN
- Defined: adds two ports.
  - sticky_clr input, CHANNELS bits.
  - sticky output, CHANNELS bits, reset value 0.
  - sticky[i] sets on any edge where updated[i] is asserted, and clears on sticky_clr[i]=1.
  - Simultaneous set and clear: set wins.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package d_reg_bank_pkg:
  - Channel state enum: ST_IDLE, ST_QUALIFY.
  - Mode constants: MODE_DIRECT=1'b0, MODE_QUAL=1'b1.
  - Counter-width helper function.
- Sub-module d_reg_chan:
  - Holds one channel's FSM, cand, cnt, q, updated, busy and sticky logic.
  - Parameters: WIDTH, STABLE_CYCLES.
- d_reg_bank instantiates CHANNELS copies of d_reg_chan in a generate loop and packs and unpacks the buses.

Test Plan:
1. Reset check (defaults): hold rstn=0 for 2 edges with d=all-ones, en=all-ones -> q=0, updated=0, busy=0. Release rstn -> on the next edge q[i]=8'hFF and updated=4'b1111 for one cycle.
2. Direct-mode enable gating (mode=0): en=4'b0101, d chans={8'h11,8'h22,8'h33,8'h44} -> after 1 edge only channels 0 and 2 load. updated=4'b0101 for one cycle; other channels hold their previous value.
3. Qualified capture (mode=1, STABLE_CYCLES=3): q[0]=8'h00, d[0]=8'hA5, en[0]=1 held -> busy[0]=1 for edges 1-2. q[0]=8'hA5 and updated[0]=1 after edge 3, then busy[0]=0.
4. Glitch and restart (mode=1): d[0] sequence A5,A5,5A,5A,5A -> no update at edge 3; q[0]=8'h5A after edge 5. Separately, sequence A5,00 with q=00 -> abort to IDLE, no updated pulse.
5. Abort conditions (mode=1):
   - Mid-qualify en[0]=0 -> busy[0]=0 next edge, q unchanged.
   - Mid-qualify rstn=0 -> q=0, busy=0.
   - Mid-qualify mode->0 with en=1 -> immediate load of d.
6. DREG_STICKY_EN build: update on channel 1 -> sticky[1]=1. Assert sticky_clr[1] on the same edge as a new update -> sticky[1] stays 1. Assert clear alone -> sticky[1]=0.

Source files
------------

// File: rtl/d_reg_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_bank_pkg
//  Description : Shared types, mode constants and the counter-width helper
//                for the d_reg_bank data-hold register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
package d_reg_bank_pkg;

    // Per-channel qualification state
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_QUALIFY = 1'b1
    } chan_state_t;

    // Values of the shared mode input
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_QUAL   = 1'b1;

    // Bits needed for a counter that has to reach stable_cycles
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_reg_chan.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_chan
//  Description : One channel of the data-hold bank. Direct mode loads the
//                input on every enabled edge; qualified mode loads it only
//                once it has been seen unchanged on STABLE_CYCLES
//                consecutive enabled edges.
//                Optional sticky-update flag when DREG_STICKY_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_reg_chan
    import d_reg_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_mode,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
`ifdef DREG_STICKY_EN
    input  logic             i_sticky_clr,
    output logic             o_sticky,
`endif
    output logic [WIDTH-1:0] o_q,
    output logic             o_updated,
    output logic             o_busy
);

    localparam int unsigned     CW          = cnt_width(STABLE_CYCLES);
    localparam logic [CW:0]     c_stable    = (CW + 1)'(STABLE_CYCLES);
    localparam logic [CW:0]     c_one_ext   = (CW + 1)'(1);
    localparam logic [CW-1:0]   c_cnt_one   = CW'(1);

    chan_state_t        r_state;
    chan_state_t        w_state_nxt;
    logic [WIDTH-1:0]   r_cand;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_q;
    logic               r_updated;

    logic               w_load;
    logic [WIDTH-1:0]   w_load_val;
    logic               w_cand_ld;
    logic [CW-1:0]      w_cnt_nxt;

    logic               w_d_ne_q;
    logic               w_d_eq_cand;
    logic               w_last;

    assign w_d_ne_q    = (i_d != r_q);
    assign w_d_eq_cand = (i_d == r_cand);
    // The current matching sample is the final one needed to qualify
    assign w_last      = (({1'b0, r_cnt} + c_one_ext) == c_stable);

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_q       <= '0;
            r_updated <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_updated <= w_load;
            if (w_cand_ld) begin
                r_cand <= i_d;
            end
            if (w_load) begin
                r_q <= w_load_val;
            end
        end
    end

    // Next-state decode; direct mode always parks the channel in IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (i_mode == MODE_DIRECT) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en && w_d_ne_q && (STABLE_CYCLES > 1)) begin
                        w_state_nxt = ST_QUALIFY;
                    end
                end
                ST_QUALIFY: begin
                    if (!i_en) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_d_eq_cand) begin
                        if (w_last) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end else if (!w_d_ne_q) begin
                        // Input fell back to the held value: it was a glitch
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Load, candidate and counter control for the current edge
    always_comb begin
        w_load     = 1'b0;
        w_load_val = i_d;
        w_cand_ld  = 1'b0;
        w_cnt_nxt  = r_cnt;
        if (i_mode == MODE_DIRECT) begin
            w_load    = i_en;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_en && w_d_ne_q) begin
                        if (STABLE_CYCLES == 1) begin
                            w_load = 1'b1;
                        end else begin
                            w_cand_ld = 1'b1;
                            w_cnt_nxt = c_cnt_one;
                        end
                    end
                end
                ST_QUALIFY: begin
                    if (!i_en) begin
                        w_cnt_nxt = '0;
                    end else if (w_d_eq_cand) begin
                        if (w_last) begin
                            w_load     = 1'b1;
                            w_load_val = r_cand;
                            w_cnt_nxt  = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + c_cnt_one;
                        end
                    end else if (w_d_ne_q) begin
                        // A different new value: restart qualification on it
                        w_cand_ld = 1'b1;
                        w_cnt_nxt = c_cnt_one;
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
                default: w_cnt_nxt = '0;
            endcase
        end
    end

    assign o_q       = r_q;
    assign o_updated = r_updated;
    assign o_busy    = (r_state == ST_QUALIFY);

`ifdef DREG_STICKY_EN
    logic r_sticky;

    // Sticky flag rises with each load; a clear on the same edge loses
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sticky <= 1'b0;
        end else if (w_load) begin
            r_sticky <= 1'b1;
        end else if (i_sticky_clr) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_sticky = r_sticky;
`endif

endmodule
`default_nettype wire

// File: rtl/d_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : d_reg_bank
//  Description : Multi-channel clocked data-hold register bank with direct
//                and deglitching (qualified) capture modes.
//                Optional macro DREG_STICKY_EN adds sticky_clr / sticky.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_reg_bank
    import d_reg_bank_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int CHANNELS      = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      mode,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS*WIDTH-1:0] d,
`ifdef DREG_STICKY_EN
    input  logic [CHANNELS-1:0]       sticky_clr,
    output logic [CHANNELS-1:0]       sticky,
`endif
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       updated,
    output logic [CHANNELS-1:0]       busy
);

    // One independent channel per slice of the packed buses
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            d_reg_chan #(
                .WIDTH         (WIDTH),
                .STABLE_CYCLES (STABLE_CYCLES)
            ) u_chan (
                .clk          (clk),
                .rstn         (rstn),
                .i_mode       (mode),
                .i_en         (en[gi]),
                .i_d          (d[gi*WIDTH +: WIDTH]),
`ifdef DREG_STICKY_EN
                .i_sticky_clr (sticky_clr[gi]),
                .o_sticky     (sticky[gi]),
`endif
                .o_q          (q[gi*WIDTH +: WIDTH]),
                .o_updated    (updated[gi]),
                .o_busy       (busy[gi])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_d_reg_bank.sv
`default_nettype none
// ============================================================================
//  Module      : tb_d_reg_bank
//  Description : Self-checking bench for d_reg_bank (WIDTH=8, CHANNELS=4,
//                STABLE_CYCLES=3) with a reference model feeding a
//                scoreboard queue. Covers DREG_STICKY_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_d_reg_bank;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int SC = 3;

    typedef struct {
        logic [CH*W-1:0] q;
        logic [CH-1:0]   upd;
        logic [CH-1:0]   busy;
        logic [CH-1:0]   sticky;
    } exp_t;

    logic            clk;
    logic            rstn;
    logic            mode;
    logic [CH-1:0]   en;
    logic [CH*W-1:0] d;
    logic [CH*W-1:0] q;
    logic [CH-1:0]   updated;
    logic [CH-1:0]   busy;
`ifdef DREG_STICKY_EN
    logic [CH-1:0]   sticky_clr;
    logic [CH-1:0]   sticky;
`endif

    int n_total = 0;
    int n_bad   = 0;

    exp_t sb[$];

    // Reference model state
    logic [W-1:0] m_q    [CH];
    logic [W-1:0] m_cand [CH];
    int           m_cnt  [CH];
    bit           m_busy [CH];
    logic [CH-1:0] m_upd;
    logic [CH-1:0] m_sticky;

    d_reg_bank #(
        .WIDTH         (W),
        .CHANNELS      (CH),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .mode       (mode),
        .en         (en),
        .d          (d),
`ifdef DREG_STICKY_EN
        .sticky_clr (sticky_clr),
        .sticky     (sticky),
`endif
        .q          (q),
        .updated    (updated),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance the reference model by one clock edge
    task automatic model_edge(input logic r, input logic md, input logic [CH-1:0] e,
                              input logic [CH*W-1:0] dd, input logic [CH-1:0] sc);
        logic [W-1:0] di;
        bit           ld;
        for (int i = 0; i < CH; i++) begin
            di = dd[i*W +: W];
            ld = 0;
            if (!r) begin
                m_q[i] = '0; m_cand[i] = '0; m_cnt[i] = 0; m_busy[i] = 0;
            end else if (md == 1'b0) begin
                m_busy[i] = 0; m_cnt[i] = 0;
                if (e[i]) begin m_q[i] = di; ld = 1; end
            end else if (!m_busy[i]) begin
                if (e[i] && di != m_q[i]) begin
                    if (SC == 1) begin m_q[i] = di; ld = 1; end
                    else begin m_cand[i] = di; m_cnt[i] = 1; m_busy[i] = 1; end
                end
            end else begin
                if (!e[i]) begin
                    m_busy[i] = 0; m_cnt[i] = 0;
                end else if (di == m_cand[i]) begin
                    if (m_cnt[i] + 1 == SC) begin
                        m_q[i] = m_cand[i]; ld = 1; m_busy[i] = 0; m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = m_cnt[i] + 1;
                    end
                end else if (di != m_q[i]) begin
                    m_cand[i] = di; m_cnt[i] = 1;
                end else begin
                    m_busy[i] = 0; m_cnt[i] = 0;
                end
            end
            m_upd[i] = r && ld;
            if (!r)           m_sticky[i] = 1'b0;
            else if (ld)      m_sticky[i] = 1'b1;
            else if (sc[i])   m_sticky[i] = 1'b0;
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, then compare
    task automatic step(input logic r, input logic md, input logic [CH-1:0] e,
                        input logic [CH*W-1:0] dd, input logic [CH-1:0] sc);
        exp_t ex;
        exp_t got_ex;
        @(negedge clk);
        rstn = r; mode = md; en = e; d = dd;
`ifdef DREG_STICKY_EN
        sticky_clr = sc;
`endif
        model_edge(r, md, e, dd, sc);
        for (int i = 0; i < CH; i++) begin
            ex.q[i*W +: W] = m_q[i];
            ex.busy[i]     = m_busy[i];
        end
        ex.upd    = m_upd;
        ex.sticky = m_sticky;
        sb.push_back(ex);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL sb_empty got=0 exp=1");
        end else begin
            got_ex = sb.pop_front();
            check_val("sb_q",    64'(q),       64'(got_ex.q));
            check_val("sb_upd",  64'(updated), 64'(got_ex.upd));
            check_val("sb_busy", 64'(busy),    64'(got_ex.busy));
`ifdef DREG_STICKY_EN
            check_val("sb_sticky", 64'(sticky), 64'(got_ex.sticky));
`endif
        end
    endtask

    function automatic logic [W-1:0] pick_val(input int unsigned k);
        logic [W-1:0] v;
        case (k)
            0:       v = 8'h00;
            1:       v = 8'hA5;
            2:       v = 8'h5A;
            default: v = 8'hFF;
        endcase
        return v;
    endfunction

    initial begin
        logic [CH*W-1:0] rd;
        logic [CH-1:0]   re;
        clk = 1'b0; rstn = 1'b0; mode = 1'b0; en = '0; d = '0;
`ifdef DREG_STICKY_EN
        sticky_clr = '0;
`endif
        for (int i = 0; i < CH; i++) begin
            m_q[i] = '0; m_cand[i] = '0; m_cnt[i] = 0; m_busy[i] = 0;
        end
        m_upd = '0; m_sticky = '0;

        // 1. Reset holds outputs at zero even with all inputs high
        step(1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0);
        step(1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0);
        check_val("rst_q",    64'(q),       64'h0);
        check_val("rst_upd",  64'(updated), 64'h0);
        check_val("rst_busy", 64'(busy),    64'h0);
        step(1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 4'h0);
        check_val("rel_q",   64'(q),       64'hFFFF_FFFF);
        check_val("rel_upd", 64'(updated), 64'hF);
        step(1'b1, 1'b0, 4'h0, 32'hFFFF_FFFF, 4'h0);
        check_val("rel_upd_off", 64'(updated), 64'h0);

        // 2. Direct-mode enable gating
        step(1'b1, 1'b0, 4'b0101, 32'h1122_3344, 4'h0);
        check_val("dir_q",   64'(q),       64'hFF22_FF44);
        check_val("dir_upd", 64'(updated), 64'h5);

        // 3. Qualified capture of A5 into channel 0 (from q0=00)
        step(1'b1, 1'b0, 4'b0001, 32'h0000_0000, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        check_val("q3_busy1", 64'(busy[0]), 64'h1);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        check_val("q3_busy2", 64'(busy[0]), 64'h1);
        check_val("q3_upd2",  64'(updated[0]), 64'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        check_val("q3_q",     64'(q[7:0]),     64'hA5);
        check_val("q3_upd3",  64'(updated[0]), 64'h1);
        check_val("q3_busy3", 64'(busy[0]),    64'h0);

        // 4. Glitch then restart: A5,A5,5A,5A,5A from q0=00
        step(1'b1, 1'b0, 4'b0001, 32'h0000_0000, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_005A, 4'h0);
        check_val("g4_noupd", 64'(updated[0]), 64'h0);
        check_val("g4_q_hold", 64'(q[7:0]),    64'h00);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_005A, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_005A, 4'h0);
        check_val("g4_q", 64'(q[7:0]), 64'h5A);
        // Glitch returning to the held value aborts without an update
        step(1'b1, 1'b0, 4'b0001, 32'h0000_0000, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_0000, 4'h0);
        check_val("g4_abort_busy", 64'(busy[0]),    64'h0);
        check_val("g4_abort_upd",  64'(updated[0]), 64'h0);

        // 5. Aborts: enable drop, reset, switch to direct mode
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        step(1'b1, 1'b1, 4'b0000, 32'h0000_00A5, 4'h0);
        check_val("a5_en_busy", 64'(busy[0]), 64'h0);
        check_val("a5_en_q",    64'(q[7:0]),  64'h00);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        step(1'b0, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        check_val("a5_rst_q",    64'(q),    64'h0);
        check_val("a5_rst_busy", 64'(busy), 64'h0);
        step(1'b1, 1'b1, 4'b0001, 32'h0000_00A5, 4'h0);
        check_val("a5_md_busy_pre", 64'(busy[0]), 64'h1);
        step(1'b1, 1'b0, 4'b0001, 32'h0000_00C3, 4'h0);
        check_val("a5_md_q",    64'(q[7:0]),     64'hC3);
        check_val("a5_md_busy", 64'(busy[0]),    64'h0);
        check_val("a5_md_upd",  64'(updated[0]), 64'h1);

`ifdef DREG_STICKY_EN
        // 6. Sticky set, set-beats-clear, then clear alone
        step(1'b1, 1'b0, 4'b0010, 32'h0000_7700, 4'h0);
        check_val("st_set", 64'(sticky[1]), 64'h1);
        step(1'b1, 1'b0, 4'b0010, 32'h0000_8800, 4'b0010);
        check_val("st_setwins", 64'(sticky[1]), 64'h1);
        step(1'b1, 1'b0, 4'b0000, 32'h0000_8800, 4'b0010);
        check_val("st_clr", 64'(sticky[1]), 64'h0);
`endif

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++) begin
                rd[i*W +: W] = pick_val($urandom_range(0, 3));
                re[i]        = ($urandom_range(0, 4) != 0);
            end
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 3) != 0), re, rd,
                 CH'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
